// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32 control FSM: opcodes, datapath
// select codes, ALU operations and state constants.
package control_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OPCODE_W = 7;

   localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [1:0] OPSEL1_RS1    = 2'b00;
   localparam logic [1:0] OPSEL1_PC     = 2'b01;
   localparam logic [1:0] OPSEL1_OLD_PC = 2'b10;
   localparam logic [1:0] OPSEL1_ZERO   = 2'b11;

   localparam logic [1:0] OPSEL2_IMM    = 2'b00;
   localparam logic [1:0] OPSEL2_FOUR   = 2'b01;
   localparam logic [1:0] OPSEL2_RS2    = 2'b10;
   localparam logic [1:0] OPSEL2_ZERO   = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   localparam logic [STATE_W-1:0] S_FETCH     = 4'd0;
   localparam logic [STATE_W-1:0] S_DECODE    = 4'd1;
   localparam logic [STATE_W-1:0] S_EXEC_R    = 4'd2;
   localparam logic [STATE_W-1:0] S_EXEC_I    = 4'd3;
   localparam logic [STATE_W-1:0] S_EXEC_U    = 4'd4;
   localparam logic [STATE_W-1:0] S_WB_ALU    = 4'd5;
   localparam logic [STATE_W-1:0] S_MEM_ADDR  = 4'd6;
   localparam logic [STATE_W-1:0] S_MEM_READ  = 4'd7;
   localparam logic [STATE_W-1:0] S_MEM_WRITE = 4'd8;
   localparam logic [STATE_W-1:0] S_BRANCH    = 4'd9;
   localparam logic [STATE_W-1:0] S_JALR_ADDR = 4'd10;
   localparam logic [STATE_W-1:0] S_LINK      = 4'd11;
   localparam logic [STATE_W-1:0] S_JUMP      = 4'd12;
   localparam logic [STATE_W-1:0] S_HALT      = 4'd13;

endpackage

// File: rtl/alu_decode_module.sv
// Combinational instruction classifier: ALU operation for the execute step
// and whether the encoding belongs to the supported RV32I subset.
module alu_decode_module
   import control_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output logic [2:0] alu_sel_o,
   output logic       supported_o
);

   logic f7_zero;
   logic f7_alt;

   assign f7_zero = (funct7_i == 7'b0000000);
   assign f7_alt  = (funct7_i == 7'b0100000);

   always_comb begin
      alu_sel_o   = ALU_ADD;
      supported_o = 1'b0;
      case (opcode_i)
         OP_R, OP_IMM: begin
            supported_o = 1'b1;
            case (funct3_i)
               3'b000:  alu_sel_o = (opcode_i == OP_R && f7_alt) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_sel_o = ALU_SLL;
               3'b010:  alu_sel_o = ALU_SLT;
               3'b100:  alu_sel_o = ALU_XOR;
               3'b101:  alu_sel_o = ALU_SRL;
               3'b110:  alu_sel_o = ALU_OR;
               3'b111:  alu_sel_o = ALU_AND;
               default: supported_o = 1'b0;
            endcase
            // funct7 only qualifies R-type ops and the immediate shifts
            if (opcode_i == OP_R) begin
               if (!(f7_zero || (f7_alt && funct3_i == 3'b000))) supported_o = 1'b0;
            end else if ((funct3_i == 3'b001 || funct3_i == 3'b101) && !f7_zero) begin
               supported_o = 1'b0;
            end
         end
         OP_LOAD, OP_STORE: supported_o = (funct3_i == 3'b010);
         OP_BRANCH: begin
            alu_sel_o   = ALU_SUB;
            supported_o = (funct3_i == 3'b000 || funct3_i == 3'b001);
         end
         OP_JALR:                  supported_o = (funct3_i == 3'b000);
         OP_JAL, OP_LUI, OP_AUIPC: supported_o = 1'b1;
         default:                  supported_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit_module.sv
// Multicycle control FSM for the RV32 core; drives every datapath enable,
// mux select, immediate format and ALU operation.
module control_unit_module
   import control_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   input  logic        zero,
   input  logic        mem_op_r,
   output logic        pc_enable,
   output logic        old_pc_enable,
   output logic        ir_reg_enable,
   output logic        alu_reg_enable,
   output logic        mem_enable,
   output logic        mem_write_enable,
   output logic        memsel_mux_select,
   output logic        regfile_mux_select,
   output logic        alu_reg_mux_select,
   output logic        rf_we,
   output logic [2:0]  imm_src,
   output logic [1:0]  opsel1_select,
   output logic [1:0]  opsel2_select,
   output logic [2:0]  alu_sel,
   output logic        illegal,
   output logic        halted
);

   logic [STATE_W-1:0]  state_q, state_d;
   logic                illegal_q, illegal_d;
   logic [OPCODE_W-1:0] opcode;
   logic [2:0]          dec_alu_sel;
   logic                dec_supported;
   logic                rd_nz;
   logic                unused_ir;

   assign opcode    = ir[6:0];
   assign rd_nz     = |ir[11:7];
   assign unused_ir = ^ir[24:15];

   alu_decode_module u_alu_decode (
      .opcode_i    (opcode),
      .funct3_i    (ir[14:12]),
      .funct7_i    (ir[31:25]),
      .alu_sel_o   (dec_alu_sel),
      .supported_o (dec_supported)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Next state and datapath controls; everything is forced low during reset
   always_comb begin
      state_d            = state_q;
      illegal_d          = illegal_q;
      pc_enable          = 1'b0;
      old_pc_enable      = 1'b0;
      ir_reg_enable      = 1'b0;
      alu_reg_enable     = 1'b0;
      mem_enable         = 1'b0;
      mem_write_enable   = 1'b0;
      memsel_mux_select  = 1'b0;
      regfile_mux_select = 1'b0;
      alu_reg_mux_select = 1'b0;
      rf_we              = 1'b0;
      imm_src            = IMM_I;
      opsel1_select      = OPSEL1_RS1;
      opsel2_select      = OPSEL2_IMM;
      alu_sel            = ALU_ADD;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_enable = 1'b1;
               if (mem_op_r) begin
                  ir_reg_enable      = 1'b1;
                  old_pc_enable      = 1'b1;
                  opsel1_select      = OPSEL1_PC;
                  opsel2_select      = OPSEL2_FOUR;
                  alu_reg_mux_select = 1'b1;
                  pc_enable          = 1'b1;
                  state_d            = S_DECODE;
               end
            end
            S_DECODE: begin
               // speculative branch/jal target lands in alu_reg
               opsel1_select  = OPSEL1_OLD_PC;
               alu_reg_enable = 1'b1;
               imm_src        = (opcode == OP_JAL) ? IMM_J : IMM_B;
               if (!dec_supported) begin
                  illegal_d = 1'b1;
                  state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
               end else begin
                  case (opcode)
                     OP_R:              state_d = S_EXEC_R;
                     OP_IMM:            state_d = S_EXEC_I;
                     OP_LUI, OP_AUIPC:  state_d = S_EXEC_U;
                     OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                     OP_BRANCH:         state_d = S_BRANCH;
                     OP_JAL:            state_d = S_LINK;
                     OP_JALR:           state_d = S_JALR_ADDR;
                     default:           state_d = S_FETCH;
                  endcase
               end
            end
            S_EXEC_R: begin
               opsel2_select  = OPSEL2_RS2;
               alu_sel        = dec_alu_sel;
               alu_reg_enable = 1'b1;
               state_d        = S_WB_ALU;
            end
            S_EXEC_I: begin
               alu_sel        = dec_alu_sel;
               alu_reg_enable = 1'b1;
               state_d        = S_WB_ALU;
            end
            S_EXEC_U: begin
               opsel1_select  = (opcode == OP_LUI) ? OPSEL1_ZERO : OPSEL1_OLD_PC;
               imm_src        = IMM_U;
               alu_reg_enable = 1'b1;
               state_d        = S_WB_ALU;
            end
            S_WB_ALU: begin
               rf_we              = rd_nz;
               regfile_mux_select = 1'b1;
               state_d            = S_FETCH;
            end
            S_MEM_ADDR: begin
               imm_src        = (opcode == OP_STORE) ? IMM_S : IMM_I;
               alu_reg_enable = 1'b1;
               state_d        = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
               mem_enable        = 1'b1;
               memsel_mux_select = 1'b1;
               if (mem_op_r) begin
                  rf_we   = rd_nz;
                  state_d = S_FETCH;
               end
            end
            S_MEM_WRITE: begin
               mem_enable        = 1'b1;
               mem_write_enable  = 1'b1;
               memsel_mux_select = 1'b1;
               state_d           = S_FETCH;
            end
            S_BRANCH: begin
               // compare only; alu_reg keeps the target computed in DECODE
               opsel2_select = OPSEL2_RS2;
               imm_src       = IMM_B;
               alu_sel       = ALU_SUB;
               pc_enable     = (ir[14:12] == 3'b000) ? zero : !zero;
               state_d       = S_FETCH;
            end
            S_JALR_ADDR: begin
               alu_reg_enable = 1'b1;
               state_d        = S_LINK;
            end
            S_LINK: begin
               opsel1_select      = OPSEL1_PC;
               opsel2_select      = OPSEL2_ZERO;
               alu_reg_mux_select = 1'b1;
               regfile_mux_select = 1'b1;
               rf_we              = rd_nz;
               state_d            = S_JUMP;
            end
            S_JUMP: begin
               pc_enable = 1'b1;
               state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
         endcase
      end
   end

   assign illegal = illegal_q && !reset;
   assign halted  = (state_q == S_HALT) && !reset;

endmodule
